// File: rtl/ahb_manager_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_manager_arbiter
// Purpose  : Two-manager AHB-Lite arbiter/mux onto one subordinate port.
//            Round-robin on NONSEQ, burst lock, and replay of responses that
//            complete while their manager is stalled.
// Revision : 1.0
// ============================================================================
module ahb_manager_arbiter #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [AddressWidth-1:0] m0_haddr,
    input  logic [1:0]              m0_htrans,
    input  logic                    m0_hwrite,
    input  logic [2:0]              m0_hsize,
    input  logic [DataWidth-1:0]    m0_hwdata,
    output logic                    m0_hready,
    output logic [DataWidth-1:0]    m0_hrdata,
    output logic                    m0_hresp,
    input  logic [AddressWidth-1:0] m1_haddr,
    input  logic [1:0]              m1_htrans,
    input  logic                    m1_hwrite,
    input  logic [2:0]              m1_hsize,
    input  logic [DataWidth-1:0]    m1_hwdata,
    output logic                    m1_hready,
    output logic [DataWidth-1:0]    m1_hrdata,
    output logic                    m1_hresp,
    output logic                    s_hsel,
    output logic [AddressWidth-1:0] s_haddr,
    output logic [1:0]              s_htrans,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [DataWidth-1:0]    s_hwdata,
    output logic                    s_hready,
    input  logic                    s_hreadyout,
    input  logic [DataWidth-1:0]    s_hrdata,
    input  logic                    s_hresp
);
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    logic a_sel_q, a_sel_d, d_sel_q, d_sel_d, d_vld_q, d_vld_d, rr_q, rr_d;
    logic held0_q, held0_d, held1_q, held1_d;
    logic hold0_resp_q, hold0_resp_d, hold1_resp_q, hold1_resp_d;
    logic [DataWidth-1:0] hold0_rdata_q, hold0_rdata_d, hold1_rdata_q, hold1_rdata_d;

    logic       req0, req1, grant0, grant1, locked, a_req, mux_sel, accept;
    logic       own0, own1, cap0, cap1;
    logic [1:0] a_htrans, mux_htrans;

    assign req0     = m0_htrans[1];
    assign req1     = m1_htrans[1];
    assign a_htrans = a_sel_q ? m1_htrans : m0_htrans;
    assign a_req    = a_htrans[1];
    assign locked   = (a_htrans == HTRANS_SEQ) || (a_htrans == HTRANS_BUSY);

    // Outside ready cycles the address owner is frozen so the subordinate sees a stable phase.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (HRESETn) begin
            if (s_hreadyout) begin
                if (locked) begin
                    grant0 = !a_sel_q;
                    grant1 = a_sel_q;
                end else if (req0 && !req1) begin
                    grant0 = 1'b1;
                end else if (req1 && !req0) begin
                    grant1 = 1'b1;
                end else if (req0 && req1) begin
                    grant0 = rr_q;
                    grant1 = !rr_q;
                end
            end else if (locked || a_req) begin
                grant0 = !a_sel_q;
                grant1 = a_sel_q;
            end
        end
    end

    assign mux_sel    = grant1 | (!grant0 & a_sel_q);
    assign mux_htrans = mux_sel ? m1_htrans : m0_htrans;
    assign accept     = s_hreadyout & ((grant0 & req0) | (grant1 & req1));

    assign s_hsel   = 1'b1;
    assign s_haddr  = mux_sel ? m1_haddr  : m0_haddr;
    assign s_hwrite = mux_sel ? m1_hwrite : m0_hwrite;
    assign s_hsize  = mux_sel ? m1_hsize  : m0_hsize;
    assign s_htrans = (grant0 | grant1) ? mux_htrans : HTRANS_IDLE;
    assign s_hwdata = d_sel_q ? m1_hwdata : m0_hwdata;
    assign s_hready = s_hreadyout;

    assign own0 = d_vld_q & !d_sel_q;
    assign own1 = d_vld_q &  d_sel_q;
    // A completing data phase whose manager is still waiting for the bus is parked for replay.
    assign cap0 = own0 & s_hreadyout & req0 & !grant0;
    assign cap1 = own1 & s_hreadyout & req1 & !grant1;

    always_comb begin
        a_sel_d       = accept ? grant1 : a_sel_q;
        d_sel_d       = accept ? grant1 : d_sel_q;
        d_vld_d       = s_hreadyout ? accept : d_vld_q;
        rr_d          = (accept && mux_htrans == HTRANS_NONSEQ) ? grant1 : rr_q;
        held0_d       = cap0 | (held0_q & !(grant0 & s_hreadyout));
        held1_d       = cap1 | (held1_q & !(grant1 & s_hreadyout));
        hold0_rdata_d = cap0 ? s_hrdata : hold0_rdata_q;
        hold1_rdata_d = cap1 ? s_hrdata : hold1_rdata_q;
        hold0_resp_d  = cap0 ? s_hresp  : hold0_resp_q;
        hold1_resp_d  = cap1 ? s_hresp  : hold1_resp_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_sel_q       <= 1'b0;
            d_sel_q       <= 1'b0;
            d_vld_q       <= 1'b0;
            rr_q          <= 1'b1;
            held0_q       <= 1'b0;
            held1_q       <= 1'b0;
            hold0_rdata_q <= '0;
            hold1_rdata_q <= '0;
            hold0_resp_q  <= 1'b0;
            hold1_resp_q  <= 1'b0;
        end else begin
            a_sel_q       <= a_sel_d;
            d_sel_q       <= d_sel_d;
            d_vld_q       <= d_vld_d;
            rr_q          <= rr_d;
            held0_q       <= held0_d;
            held1_q       <= held1_d;
            hold0_rdata_q <= hold0_rdata_d;
            hold1_rdata_q <= hold1_rdata_d;
            hold0_resp_q  <= hold0_resp_d;
            hold1_resp_q  <= hold1_resp_d;
        end
    end

    always_comb begin
        if (held0_q)   m0_hready = grant0 & s_hreadyout;
        else if (own0) m0_hready = s_hreadyout & (grant0 | !req0);
        else if (req0) m0_hready = grant0 & s_hreadyout;
        else           m0_hready = 1'b1;
        if (!HRESETn)  m0_hready = 1'b1;

        if (held1_q)   m1_hready = grant1 & s_hreadyout;
        else if (own1) m1_hready = s_hreadyout & (grant1 | !req1);
        else if (req1) m1_hready = grant1 & s_hreadyout;
        else           m1_hready = 1'b1;
        if (!HRESETn)  m1_hready = 1'b1;
    end

    assign m0_hrdata = held0_q ? hold0_rdata_q : s_hrdata;
    assign m1_hrdata = held1_q ? hold1_rdata_q : s_hrdata;
    assign m0_hresp  = held0_q ? hold0_resp_q  : (own0 & s_hresp);
    assign m1_hresp  = held1_q ? hold1_resp_q  : (own1 & s_hresp);
endmodule
`default_nettype wire

// File: tb/tb_ahb_manager_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_manager_arbiter
// Purpose  : Random two-manager traffic against a subordinate model with wait
//            states and ERROR responses; scoreboard plus arbitration model.
// Revision : 1.0
// ============================================================================
module tb_ahb_manager_arbiter;
    localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
    typedef struct packed { logic [31:0] addr; logic wr; logic [2:0] size; } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_haddr  [2];
    logic [1:0]  m_htrans [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize  [2];
    logic [31:0] m_hwdata [2];
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;

    wire [1:0]  hr    = {m1_hready, m0_hready};
    wire [1:0]  hrs   = {m1_hresp, m0_hresp};
    wire [63:0] hrd_p = {m1_hrdata, m0_hrdata};

    ahb_manager_arbiter #(.AddressWidth(32), .DataWidth(32)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .m0_haddr(m_haddr[0]), .m0_htrans(m_htrans[0]), .m0_hwrite(m_hwrite[0]),
        .m0_hsize(m_hsize[0]), .m0_hwdata(m_hwdata[0]),
        .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
        .m1_haddr(m_haddr[1]), .m1_htrans(m_htrans[1]), .m1_hwrite(m_hwrite[1]),
        .m1_hsize(m_hsize[1]), .m1_hwdata(m_hwdata[1]),
        .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hreadyout(s_hreadyout), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input logic ok, input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction
    function automatic logic [31:0] wd_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction
    function automatic logic err_fn(input logic [31:0] a);
        return a[6:2] == 5'h1F;
    endfunction

    // Expected manager-side completions and subordinate-side address phases, per manager.
    xfer_t eq0[$], eq1[$], sq0[$], sq1[$];

    // ---------------- stimulus: managers + subordinate ----------------
    int          beats [2];
    bit          force_pair, issue_en;
    logic [1:0]  smp_hr, smp_strans;
    logic [31:0] smp_saddr;
    logic        smp_swrite;
    logic        sub_vld, sub_wr, sub_err, sub_err_done;
    logic [31:0] sub_addr;
    int          sub_cnt;

    task automatic push_issue(input int i);
        xfer_t x;
        x = '{addr: m_haddr[i], wr: m_hwrite[i], size: m_hsize[i]};
        if (i == 0) begin eq0.push_back(x); sq0.push_back(x); end
        else        begin eq1.push_back(x); sq1.push_back(x); end
    endtask

    task automatic mgr_update(input int i, input logic rdy);
        if (!rdy) return;
        if (m_htrans[i][1] && m_hwrite[i]) m_hwdata[i] = wd_fn(m_haddr[i]);
        else                               m_hwdata[i] = $urandom;
        if (beats[i] > 0) begin
            m_haddr[i]  = m_haddr[i] + 32'd4;
            m_htrans[i] = T_SEQ;
            beats[i]--;
            push_issue(i);
        end else if (force_pair || (issue_en && $urandom_range(0, 2) != 0)) begin
            m_haddr[i]  = {15'd0, 1'(i), 4'd0, 10'($urandom), 2'b00};
            m_htrans[i] = T_NONSEQ;
            m_hwrite[i] = force_pair ? 1'b0 : 1'($urandom_range(0, 1));
            m_hsize[i]  = force_pair ? 3'd2 : 3'($urandom_range(0, 2));
            beats[i]    = (!force_pair && $urandom_range(0, 1) == 1) ? 3 : 0;
            push_issue(i);
        end else begin
            m_htrans[i] = T_IDLE;
            m_haddr[i]  = $urandom;
            m_hwrite[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sub_update();
        if (s_hreadyout) begin
            if (smp_strans[1]) begin
                sub_vld      = 1'b1;
                sub_addr     = smp_saddr;
                sub_wr       = smp_swrite;
                sub_cnt      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                sub_err      = err_fn(smp_saddr);
                sub_err_done = 1'b0;
            end else begin
                sub_vld = 1'b0;
            end
        end else if (sub_cnt > 0) begin
            sub_cnt--;
        end else begin
            sub_err_done = 1'b1;
        end
        s_hrdata = $urandom;
        if (!sub_vld)                      begin s_hreadyout = 1'b1; s_hresp = 1'b0; end
        else if (sub_cnt > 0)              begin s_hreadyout = 1'b0; s_hresp = 1'b0; end
        else if (sub_err && !sub_err_done) begin s_hreadyout = 1'b0; s_hresp = 1'b1; end
        else begin
            s_hreadyout = 1'b1;
            s_hresp     = sub_err;
            if (!sub_wr) s_hrdata = rd_fn(sub_addr);
        end
    endtask

    task automatic step();
        @(negedge clk);
        smp_hr     = hr;
        smp_strans = s_htrans;
        smp_saddr  = s_haddr;
        smp_swrite = s_hwrite;
        @(posedge clk);
        #1;
        sub_update();
        mgr_update(0, smp_hr[0]);
        mgr_update(1, smp_hr[1]);
        force_pair = 1'b0;
    endtask

    task automatic quiesce();
        for (int i = 0; i < 2; i++) begin
            m_htrans[i] = T_IDLE; m_haddr[i] = '0; m_hwrite[i] = 1'b0;
            m_hsize[i] = 3'd2; m_hwdata[i] = '0; beats[i] = 0;
        end
        sub_vld = 1'b0; sub_cnt = 0; s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
        eq0.delete(); eq1.delete(); sq0.delete(); sq1.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk(s_htrans == T_IDLE, {tag, "_htrans"}, 32'(s_htrans), 0);
        chk(m0_hready == 1'b1, {tag, "_m0_hready"}, 32'(m0_hready), 1);
        chk(m1_hready == 1'b1, {tag, "_m1_hready"}, 32'(m1_hready), 1);
        chk(m0_hresp == 1'b0, {tag, "_m0_hresp"}, 32'(m0_hresp), 0);
        chk(m1_hresp == 1'b0, {tag, "_m1_hresp"}, 32'(m1_hresp), 0);
        chk(s_hsel == 1'b1, {tag, "_hsel"}, 32'(s_hsel), 1);
    endtask

    initial begin
        rst_n = 1'b0; force_pair = 1'b0; issue_en = 1'b0;
        quiesce();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1; force_pair = 1'b1; issue_en = 1'b1;
        repeat (1500) step();
        // Drop reset while M1 is mid-burst; outputs must go idle immediately.
        for (int k = 0; k < 400 && m_htrans[1] != T_SEQ; k++) step();
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        quiesce();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; force_pair = 1'b1;
        repeat (1500) step();
        issue_en = 1'b0;
        repeat (40) step();
        chk(eq0.size() == 0, "m0_outstanding", 32'(eq0.size()), 0);
        chk(eq1.size() == 0, "m1_outstanding", 32'(eq1.size()), 0);
        chk(sq0.size() == 0, "sub_m0_unseen", 32'(sq0.size()), 0);
        chk(sq1.size() == 0, "sub_m1_unseen", 32'(sq1.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- monitor: arbitration model + scoreboard ----------------
    logic       mon_asel, mon_rr, mon_have, mon_w, mon_id, sdp_v;
    logic [1:0] mon_req, mdp;
    xfer_t      sdp_x, sx, ex;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_asel = 1'b0; mon_rr = 1'b1; sdp_v = 1'b0; mdp = 2'b00;
        end else begin
            chk(s_hready == s_hreadyout, "s_hready", 32'(s_hready), 32'(s_hreadyout));
            mon_req = {m_htrans[1][1], m_htrans[0][1]};
            if (s_hreadyout) begin
                mon_have = 1'b1;
                mon_w    = 1'b0;
                if (m_htrans[mon_asel] == T_SEQ) mon_w = mon_asel;
                else if (mon_req == 2'b01)       mon_w = 1'b0;
                else if (mon_req == 2'b10)       mon_w = 1'b1;
                else if (mon_req == 2'b11)       mon_w = !mon_rr;
                else                             mon_have = 1'b0;
                if (mon_have) begin
                    chk(s_htrans == m_htrans[mon_w] && s_haddr == m_haddr[mon_w], "grant_addr",
                        s_haddr, m_haddr[mon_w]);
                    chk(hr[mon_w] == 1'b1, "winner_hready", 32'(hr[mon_w]), 1);
                    if (mon_req[!mon_w]) chk(hr[!mon_w] == 1'b0, "loser_hready", 32'(hr[!mon_w]), 0);
                    if (mon_req[mon_w]) begin
                        mon_asel = mon_w;
                        if (m_htrans[mon_w] == T_NONSEQ) mon_rr = mon_w;
                    end
                end else begin
                    chk(s_htrans == T_IDLE, "idle_htrans", 32'(s_htrans), 0);
                end
                if (sdp_v && sdp_x.wr)
                    chk(s_hwdata == wd_fn(sdp_x.addr), "sub_hwdata", s_hwdata, wd_fn(sdp_x.addr));
                sdp_v = 1'b0;
                if (s_htrans[1]) begin
                    mon_id = s_haddr[16];
                    if ((mon_id && sq1.size() == 0) || (!mon_id && sq0.size() == 0)) begin
                        chk(1'b0, "sub_unexpected", s_haddr, 0);
                    end else begin
                        if (mon_id) sx = sq1.pop_front();
                        else        sx = sq0.pop_front();
                        chk(s_haddr == sx.addr && s_hwrite == sx.wr && s_hsize == sx.size, "sub_addr",
                            s_haddr, sx.addr);
                        sdp_v = 1'b1;
                        sdp_x = sx;
                    end
                end
            end else if (s_hresp && sdp_v) begin
                mon_id = sdp_x.addr[16];
                chk(hrs[mon_id] == 1'b1 && hr[mon_id] == 1'b0, "err_first_cycle",
                    32'({hrs[mon_id], hr[mon_id]}), 32'h2);
            end
            for (int i = 0; i < 2; i++) begin
                if (hr[i]) begin
                    if (mdp[i]) begin
                        if ((i == 0 && eq0.size() == 0) || (i == 1 && eq1.size() == 0)) begin
                            chk(1'b0, "mgr_unexpected", 32'(i), 0);
                        end else begin
                            if (i == 0) ex = eq0.pop_front();
                            else        ex = eq1.pop_front();
                            chk(hrs[i] == err_fn(ex.addr), "mgr_hresp", 32'(hrs[i]), 32'(err_fn(ex.addr)));
                            if (!ex.wr)
                                chk(hrd_p[i*32 +: 32] == rd_fn(ex.addr), "mgr_hrdata",
                                    hrd_p[i*32 +: 32], rd_fn(ex.addr));
                        end
                    end
                    mdp[i] = m_htrans[i][1];
                end
            end
        end
    end
endmodule
`default_nettype wire
